// File: rtl/seq_umulti.sv
// Sequential shift-add multiplier: one step per cycle, optional signed mode via SEQ_UMULTI_SIGNED_EN.
// Latency: out_valid rises exactly WIDTH edges after the accepting edge.
// Backpressure: in_ready only in IDLE; product held in DONE until out_ready, no accept on that edge.
module seq_umulti #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic [2*WIDTH-1:0] p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step, prod_fin;

    // Upper half accumulates, lower half holds the shrinking multiplier.
    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {sum, acc_q[WIDTH-1:1]};

`ifdef SEQ_UMULTI_SIGNED_EN
    logic neg_q;

    assign a_mag    = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag    = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign prod_fin = neg_q ? (~acc_step + 1'b1) : acc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end
`else
    logic unused_sgn;

    assign unused_sgn = sgn;
    assign a_mag      = a;
    assign b_mag      = b;
    assign prod_fin   = acc_step;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    acc_d   = {{WIDTH{1'b0}}, b_mag};
                    mcand_d = a_mag;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    p_d     = prod_fin;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign p         = p_q;

endmodule
